pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register. It is the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches. Data width and the bubble value are generic, and the stage carries a valid/ready handshake, an optional two-entry skid buffer and a synchronous flush. It is instantiated between any two pipeline stages so that hazard logic can stall or squash the stage without bespoke latch code.

Parameters:
WIDTH, 32, payload width in bits (≥1)
NOP_VALUE, 0, payload driven on out_data when the stage is empty, flushed or in reset (bubble)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  input  1  rising-edge clock
R  input  1  reset; asynchronous, active-low
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
flush  input  1  synchronous squash of all held entries
out_valid  output  1  out_data holds a live payload
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  payload to downstream

Behaviour:
- Transfer rules: accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- Reset (R low, asynchronous):
  - out_valid=0, out_data=NOP_VALUE, state EMPTY.
  - in_ready=0 while R is low, then 1 on the first clk edge after R rises.
- SKID=1 state machine, all outputs registered:
  - States: EMPTY (0 entries), ONE (main entry only), TWO (main + skid entry).
  - EMPTY: accept → ONE, main<=in_data.
  - ONE, accept && !emit → TWO, skid<=in_data.
  - ONE, accept && emit → ONE, main<=in_data.
  - ONE, emit only → EMPTY.
  - TWO: emit → ONE, main<=skid. No accept is possible in TWO.
  - in_ready = (state!=TWO), registered.
  - out_valid = (state!=EMPTY).
- SKID=0:
  - Single entry.
  - in_ready = !out_valid || out_ready (combinational).
  - A simultaneous accept and emit replaces the entry in the same cycle.
- Latency: 1 cycle from accept to out_valid when downstream is idle. Throughput is 1 payload per cycle with out_ready held high.
- Ordering: FIFO order is preserved. No payload is duplicated or dropped except by flush.
- out_data equals NOP_VALUE whenever out_valid=0. It is never stale.
- flush:
  - State goes to EMPTY and out_data to NOP_VALUE at the next edge.
  - A payload accepted in the same cycle as flush is discarded.
  - flush overrides emit; a downstream that samples with out_ready in that cycle still sees the pre-flush valid payload, which downstream hazard logic must ignore.
- out_valid && !out_ready: out_data and out_valid are held stable until emit or flush.
- Reset asserted mid-transfer: all entries are lost immediately; the outputs take their reset values asynchronously.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, two extra outputs are added:
  - stall_cnt (16 bits): counts cycles with out_valid && !out_ready.
  - bubble_cnt (16 bits): counts cycles with !out_valid.
- Counter behaviour:
  - Both saturate at 16'hFFFF and clear on reset.
  - flush does not clear them.
- When undefined, neither port nor counter exists. Core behaviour is identical in both builds.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding (PS_EMPTY=2'd0, PS_ONE=2'd1, PS_TWO=2'd2);
  - the stats counter width constant PIPE_STAT_W=16;
  - the ARM NOP encoding constant NOP_INSTR=32'hE1A00000 for IF/ID instances.
- One sub-module is natural: pipe_sat_counter, a saturating counter instanced twice under PIPE_STAGE_STATS_EN.

Test Plan:
- Reset/NOP: R low for 3 cycles with NOP_VALUE=32'hE1A00000 → out_valid=0, out_data=32'hE1A00000, in_ready=0; after R rises, in_ready=1 on the next edge.
- Streaming: SKID=1, out_ready=1, inject 32'h00000001..32'h00000008 back to back → same 8 values emitted in order, each 1 cycle later, no gaps.
- Backpressure/skid: drive 32'hA, 32'hB with out_ready=0 → state TWO, in_ready=0, out_data=32'hA; raise out_ready → emits A then B, and in_ready returns to 1 one cycle after A leaves.
- Flush collision: in TWO (A, B held), pulse flush while in_valid=1 with data C → next cycle out_valid=0, out_data=NOP_VALUE, C never appears.
- SKID=0 replace: hold entry 32'h5 with out_ready=1 and in_valid=1 data 32'h6 → in_ready=1 combinationally, 5 emitted, 6 present the next cycle.
- Stats (PIPE_STAGE_STATS_EN): hold a valid entry with out_ready=0 for 70000 cycles → stall_cnt=16'hFFFF, bubble_cnt unchanged during the stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipe_stage_reg: state encoding, stats width and the ARM NOP bubble.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

  localparam int PIPE_STAT_W = 16;

  // MOV r0,r0 -- bubble value for IF/ID instances
  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the optional pipeline stall/bubble statistics.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int W = PIPE_STAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready, optional skid entry and flush.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt/bubble_cnt statistics outputs.
//
// state    | meaning
// PS_EMPTY | no entry held, out_data is the bubble value
// PS_ONE   | main entry valid on out_data
// PS_TWO   | main entry plus skid entry, upstream stalled
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               SKID      = 1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [PIPE_STAT_W-1:0] stall_cnt,
  output logic [PIPE_STAT_W-1:0] bubble_cnt
`endif
);

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_e      state;
      logic [WIDTH-1:0] main_q;
      logic [WIDTH-1:0] skid_q;
      logic             rdy_q;
      logic             ov_q;
      logic             accept;
      logic             emit;

      assign accept = in_valid && rdy_q;
      assign emit   = ov_q && out_ready;

      always_ff @(posedge clk or negedge R) begin
        if (!R) begin
          state  <= PS_EMPTY;
          main_q <= NOP_VALUE;
          skid_q <= NOP_VALUE;
          rdy_q  <= 1'b0;
          ov_q   <= 1'b0;
        end else if (flush) begin
          // flush wins over any accept or emit in the same cycle
          state  <= PS_EMPTY;
          main_q <= NOP_VALUE;
          skid_q <= NOP_VALUE;
          rdy_q  <= 1'b1;
          ov_q   <= 1'b0;
        end else begin
          rdy_q <= 1'b1;
          case (state)
            PS_EMPTY: begin
              if (accept) begin
                state  <= PS_ONE;
                main_q <= in_data;
                ov_q   <= 1'b1;
              end
            end
            PS_ONE: begin
              if (accept && !emit) begin
                state  <= PS_TWO;
                skid_q <= in_data;
                rdy_q  <= 1'b0;
              end else if (accept) begin
                main_q <= in_data;
              end else if (emit) begin
                state  <= PS_EMPTY;
                main_q <= NOP_VALUE;
                ov_q   <= 1'b0;
              end
            end
            PS_TWO: begin
              if (emit) begin
                state  <= PS_ONE;
                main_q <= skid_q;
                skid_q <= NOP_VALUE;
              end else begin
                rdy_q <= 1'b0;
              end
            end
            default: begin
              state  <= PS_EMPTY;
              main_q <= NOP_VALUE;
              skid_q <= NOP_VALUE;
              ov_q   <= 1'b0;
            end
          endcase
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = ov_q;
      assign out_data  = main_q;
    end else begin : g_single
      logic [WIDTH-1:0] main_q;
      logic             ov_q;
      logic             rdy_en_q;
      logic             accept;
      logic             emit;

      // rdy_en_q keeps in_ready low through reset and until the first edge after it
      assign in_ready = rdy_en_q && (!ov_q || out_ready);
      assign accept   = in_valid && in_ready;
      assign emit     = ov_q && out_ready;

      always_ff @(posedge clk or negedge R) begin
        if (!R) begin
          main_q   <= NOP_VALUE;
          ov_q     <= 1'b0;
          rdy_en_q <= 1'b0;
        end else begin
          rdy_en_q <= 1'b1;
          if (flush) begin
            main_q <= NOP_VALUE;
            ov_q   <= 1'b0;
          end else if (accept) begin
            main_q <= in_data;
            ov_q   <= 1'b1;
          end else if (emit) begin
            main_q <= NOP_VALUE;
            ov_q   <= 1'b0;
          end
        end
      end

      assign out_valid = ov_q;
      assign out_data  = main_q;
    end
  endgenerate

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_counter #(.W(PIPE_STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (R),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(PIPE_STAT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (R),
    .inc   (!out_valid),
    .count (bubble_cnt)
  );
`endif

endmodule
